// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: two-master MIO bus arbiter with round-robin or fixed priority
// and a slave-ready watchdog that terminates unacknowledged transactions.
module mio_bus_arbiter #(
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_breq,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_breq,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_breq,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ERR = 2'd3} state_t;
    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);
    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_last, r_owner;
    logic        w_gnt, w_sel1, w_breq, w_done, w_err, w_act;
    assign w_gnt  = (r_state == GNT0) || (r_state == GNT1);
    // ERR keeps pointing at the master whose transaction timed out
    assign w_sel1 = (r_state == GNT1) || ((r_state == ERR) && r_owner);
    assign w_breq = w_sel1 ? m1_breq : m0_breq;
    assign w_done = w_gnt && s_ready;
    assign w_err  = r_state == ERR;
    assign w_act  = r_state != IDLE;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = (m0_breq && (!m1_breq || !RR_EN || r_last)) ? GNT0 :
                                 m1_breq ? GNT1 : IDLE;
            GNT0, GNT1: w_next = (s_ready || !w_breq) ? IDLE :
                                 (r_cnt == LIMIT) ? ERR : r_state;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_gnt && w_next == r_state) ? r_cnt + 16'd1 : 16'd0;
            if (w_gnt)
                r_owner <= r_state == GNT1;
            if (w_done || w_err)
                r_last <= w_sel1;
        end
    end
    assign state    = r_state;
    assign grant    = {w_act && w_sel1, w_act && !w_sel1};
    assign s_breq   = w_gnt && w_breq;
    assign s_we     = w_gnt && (w_sel1 ? m1_we : m0_we);
    assign s_addr   = w_gnt ? (w_sel1 ? m1_addr : m0_addr) : 32'd0;
    assign s_wdata  = w_gnt ? (w_sel1 ? m1_wdata : m0_wdata) : 32'd0;
    assign m0_ready = (w_done || w_err) && !w_sel1;
    assign m1_ready = (w_done || w_err) && w_sel1;
    assign m0_err   = w_err && !w_sel1;
    assign m1_err   = w_err && w_sel1;
    assign m0_rdata = (w_done && !w_sel1) ? s_rdata : 32'd0;
    assign m1_rdata = (w_done && w_sel1) ? s_rdata : 32'd0;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: table-driven vectors on a round-robin instance (TIMEOUT=8)
// plus a starvation sequence on a fixed-priority instance.
module tb_mio_bus_arbiter;
    localparam logic [31:0] M0A = 32'h0000_0010, M0D = 32'hAAAA_5555;
    localparam logic [31:0] M1A = 32'hE000_0000, M1D = 32'h1234_5678;
    localparam logic [31:0] SRD = 32'hDEAD_BEEF;
    logic        clk = 1'b0, reset = 1'b0;
    logic        m0_breq = 1'b0, m1_breq = 1'b0, s_ready = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b1;
    logic [31:0] m0_addr = M0A, m0_wdata = M0D, m1_addr = M1A, m1_wdata = M1D, s_rdata = SRD;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ready, m0_err, m1_ready, m1_err, s_breq, s_we;
    logic [1:0]  grant, state;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
    logic        f_m0_ready, f_m0_err, f_m1_ready, f_m1_err, f_s_breq, f_s_we;
    logic [1:0]  f_grant, f_state;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset(reset),
        .m0_breq(m0_breq), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_breq(m1_breq), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_breq(s_breq), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .state(state)
    );

    mio_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(8)) u_fp (
        .clk(clk), .reset(reset),
        .m0_breq(m0_breq), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready), .m0_err(f_m0_err),
        .m1_breq(m1_breq), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready), .m1_err(f_m1_err),
        .s_breq(f_s_breq), .s_we(f_s_we), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(f_grant), .state(f_state)
    );

    // in = {reset, m0_breq, m1_breq, s_ready}; rt = master routed to slave (0 none, 1 m0, 2 m1)
    // rdy/err/rd bit0 = m0, bit1 = m1; rd marks rdata expected equal to s_rdata
    typedef struct packed {
        logic [3:0] in;
        logic [1:0] st, gnt;
        logic       sb;
        logic [1:0] rt, rdy, err, rd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int in, st, gnt, sb, rt, rdy, err, rd);
        tbl.push_back(vec_t'{4'(in), 2'(st), 2'(gnt), 1'(sb), 2'(rt), 2'(rdy), 2'(err), 2'(rd)});
    endtask

    task automatic idle(input int in);
        add(in, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rep(input int k, input int in, st, gnt, sb, rt);
        for (int i = 0; i < k; i++) add(in, st, gnt, sb, rt, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [137:0] got, input logic [137:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    initial begin
        logic [137:0] got, exp;
        idle('b0110);
        idle('b1110);
        add('b1111, 1, 1, 1, 1, 1, 0, 1);
        idle('b1110);
        add('b1111, 2, 2, 1, 2, 2, 0, 2);
        idle('b1110);
        add('b1111, 1, 1, 1, 1, 1, 0, 1);
        idle('b1110);
        add('b1111, 2, 2, 1, 2, 2, 0, 2);
        idle('b1100);
        rep(3, 'b1100, 1, 1, 1, 1);
        add('b1101, 1, 1, 1, 1, 1, 0, 1);
        idle('b1000);
        idle('b1011);
        rep(1, 'b1010, 2, 2, 1, 2);
        add('b1011, 2, 2, 1, 2, 2, 0, 2);
        idle('b1000);
        idle('b1010);
        rep(2, 'b1010, 2, 2, 1, 2);
        rep(1, 'b1000, 2, 2, 0, 2);
        idle('b1000);
        idle('b1100);
        rep(8, 'b1100, 1, 1, 1, 1);
        add('b1101, 3, 1, 0, 0, 1, 1, 0);
        idle('b1000);
        idle('b1100);
        rep(7, 'b1100, 1, 1, 1, 1);
        add('b1101, 1, 1, 1, 1, 1, 0, 1);
        idle('b1000);
        idle('b1100);
        rep(1, 'b1100, 1, 1, 1, 1);
        idle('b0101);
        idle('b1000);
        foreach (tbl[i]) begin
            @(posedge clk);
            #1 {reset, m0_breq, m1_breq, s_ready} = tbl[i].in;
            @(negedge clk);
            got = {state, grant, s_breq, s_we, s_addr, s_wdata,
                   m0_ready, m1_ready, m0_err, m1_err, m0_rdata, m1_rdata};
            exp = {tbl[i].st, tbl[i].gnt, tbl[i].sb, tbl[i].rt == 2'd2,
                   tbl[i].rt == 2'd1 ? M0A : tbl[i].rt == 2'd2 ? M1A : 32'd0,
                   tbl[i].rt == 2'd1 ? M0D : tbl[i].rt == 2'd2 ? M1D : 32'd0,
                   tbl[i].rdy[0], tbl[i].rdy[1], tbl[i].err[0], tbl[i].err[1],
                   tbl[i].rd[0] ? SRD : 32'd0, tbl[i].rd[1] ? SRD : 32'd0};
            chk($sformatf("vec%0d", i), got, exp);
        end
        @(posedge clk);
        #1 reset = 1'b0; m0_breq = 1'b1; m1_breq = 1'b1; s_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (f_grant == 2'b00 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("fp_wait%0d", t), 138'(n < 10), 138'(1));
            chk($sformatf("fp_grant%0d", t), 138'(f_grant), 138'(2'b01));
            s_ready = 1'b1;
            #1 chk($sformatf("fp_ready%0d", t), 138'({f_m0_ready, f_m1_ready}), 138'(2'b10));
            @(posedge clk);
            #1 s_ready = 1'b0;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
